// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_t   : 3-bit FSM encoding (IDLE/LOAD/SEND/WAIT_LO/WAIT_HI)
//   BYTE_W        : width of one transmitted byte
//   DEF_MAX_BURST : default bytes per grant before forced re-arbitration
//   DEF_TIMEOUT   : default cycles to wait for the UART to take a byte
//                   (only meaningful when UART_ARB_TIMEOUT_EN is defined)
package uart_arb_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches req_valid upward starting at
// last_grant+1, wrapping at NUM_REQ, and returns the first valid index.
//   req_valid  : request vector
//   last_grant : index granted most recently (lowest priority this round)
//   next_id    : chosen index (0 when nothing is valid)
//   found      : at least one request was valid
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [2:0]         last_grant,
    output logic [2:0]         next_id,
    output logic               found
);

    // Two passes instead of a modulo: first the indices above last_grant,
    // then the wrapped-around ones up to and including last_grant.
    always_comb begin
        found   = 1'b0;
        next_id = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i > int'(last_grant))) begin
                found   = 1'b1;
                next_id = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i <= int'(last_grant))) begin
                found   = 1'b1;
                next_id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters with
// round-robin arbitration at message granularity. A grant lasts until the
// owner's last byte or MAX_BURST bytes, whichever comes first.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   uart_data_in, uart_data_in_en, uart_data_in_rdy : transmitter handshake
//   grant_valid, grant_id : current owner
//   busy               : FSM not in IDLE
//   err_timeout        : sticky timeout flag
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a byte the UART
// has not taken within TIMEOUT cycles. Without it err_timeout is tied low.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         uart_data_in,
    output logic                      uart_data_in_en,
    input  logic                      uart_data_in_rdy,
    output logic                      grant_valid,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    arb_state_t        state;
    logic [2:0]        last_grant;
    logic [7:0]        burst_cnt;
    logic              last_q;
    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_data;
    logic [2:0]        pick_id;
    logic              pick_found;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]       to_cnt;
`endif

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .next_id   (pick_id),
        .found     (pick_found)
    );

    // Owner's lane, and a ready that only the owner can ever see.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*BYTE_W +: BYTE_W];
            end
            req_ready[i] = (state == LOAD) && (grant_id == 3'(i)) &&
                           req_valid[i] && uart_data_in_rdy;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            uart_data_in    <= '0;
            uart_data_in_en <= 1'b0;
            grant_valid     <= 1'b0;
            grant_id        <= 3'd0;
            last_grant      <= 3'(NUM_REQ - 1);
            burst_cnt       <= 8'd0;
            last_q          <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt          <= 16'd0;
            err_timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        burst_cnt   <= 8'd0;
                        state       <= LOAD;
                    end
                end
                // An owner that pauses keeps the grant: messages are atomic.
                LOAD: begin
                    if (sel_valid && uart_data_in_rdy) begin
                        uart_data_in    <= sel_data;
                        last_q          <= sel_last;
                        uart_data_in_en <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    uart_data_in_en <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt          <= 16'd0;
`endif
                    state           <= WAIT_LO;
                end
                // The falling edge of rdy is the UART's acknowledgement.
                WAIT_LO: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (!uart_data_in_rdy) begin
                        state <= WAIT_HI;
                    end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        last_grant  <= grant_id;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`else
                    if (!uart_data_in_rdy) begin
                        state <= WAIT_HI;
                    end
`endif
                end
                WAIT_HI: begin
                    if (uart_data_in_rdy) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (last_q || (burst_cnt == 8'(MAX_BURST - 1))) begin
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, for example the debug console, the status reporter and the loader echo.
- Arbitrates round-robin at message granularity: a granted requester keeps the transmitter until it sends its last byte or hits MAX_BURST bytes.
- Sequences the transmitter byte handshake (data_in / data_in_en / data_in_rdy) so requesters never see UART timing.
- Sits between the requesters and the uart block, in the clk domain (81.25 MHz).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before a forced re-arbitration (1..255).
- TIMEOUT, 1024, cycles to wait for the UART to accept a byte (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data.
- req_data  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its message.
- req_ready  out  NUM_REQ  one-hot accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
- uart_data_in  out  8  byte to the transmitter.
- uart_data_in_en  out  1  one-cycle send strobe.
- uart_data_in_rdy  in  1  transmitter idle/ready.
- grant_valid  out  1  a requester currently owns the UART.
- grant_id  out  3  index of the owning requester.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; uart_data_in=0, uart_data_in_en=0.
  - grant_valid=0, grant_id=0, last_grant=NUM_REQ-1, burst_cnt=0, err_timeout=0.
  - req_ready=0 (it is combinational from state).
- A reset in the middle of a byte drops that byte and the grant. Requesters must retransmit.
- States:
  - IDLE: if any req_valid, set grant_id = first index with req_valid, searching upward from last_grant+1 with wrap. Set grant_valid=1, burst_cnt=0, go to LOAD. No requester valid: stay in IDLE.
  - LOAD: req_ready[grant_id] = req_valid[grant_id] & uart_data_in_rdy; all other req_ready bits are 0.
    - On transfer: latch the byte into uart_data_in, latch req_last into last_q, go to SEND.
    - If the owner deasserts req_valid, hold LOAD and keep the grant (messages are atomic).
  - SEND: uart_data_in_en=1 for exactly this cycle, then go to WAIT_LO.
  - WAIT_LO: wait for uart_data_in_rdy=0 (byte accepted), then go to WAIT_HI.
  - WAIT_HI: wait for uart_data_in_rdy=1 (stop bit done), then burst_cnt++.
    - If last_q, or burst_cnt reaches MAX_BURST-1 before the increment: last_grant=grant_id, grant_valid=0, go to IDLE.
    - Otherwise go to LOAD.
- Latency: request in IDLE → earliest req_ready 1 cycle later → uart_data_in_en 1 cycle after the transfer.
- Minimum gap between a requester's bytes is set by the UART frame; the arbiter adds 2 cycles.
- Forced release at MAX_BURST: the requester keeps req_valid high and the rest of its message competes in the next round. The message is split, which is intended.
- Simultaneous requests in IDLE: the round-robin search decides. The requester just released gets lowest priority.
- If it is the only requester, it is re-granted immediately.
- uart_data_in stays stable from SEND until the next transfer.
- uart_data_in_en is never high outside SEND.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter runs in WAIT_LO.
  - If uart_data_in_rdy stays 1 for TIMEOUT cycles, set err_timeout=1 (sticky until reset), drop the grant and go to IDLE.
  - last_grant is updated so the failing requester loses priority.
- Without the macro:
  - err_timeout is tied to 0.
  - WAIT_LO waits indefinitely.
  - No counter logic is generated.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding constants IDLE/LOAD/SEND/WAIT_LO/WAIT_HI (3 bits);
  - BYTE_W=8;
  - default MAX_BURST and TIMEOUT constants.
- One sub-module: rr_pick. It is combinational: inputs req_valid and last_grant, outputs the next index and a found flag. It is reusable by a future rx dispatcher.

Test Plan:
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43 (UART model rdy drops 1 cycle after en, frame 10 clocks) → exactly 3 en pulses in order, then grant_valid=0 and busy=0.
- Requesters 1 and 2 both valid from IDLE with last_grant=3 → grant 1 first. Then with grant released, 2 messages per requester in order 1,2,1,2.
- Requester 0 sends an 20-byte message with MAX_BURST=16 while requester 3 is waiting → after 16 bytes grant goes to 3, then to 0 for the remaining 4 bytes.
- Owner drops req_valid for 50 cycles mid-message while requester 1 is valid → grant held, no en pulses, resumes after req_valid returns.
- rst_n pulsed low during WAIT_HI → all outputs at reset values asynchronously; after release a new arbitration starts at requester 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=32, UART model never drops rdy → err_timeout=1 at 32 cycles after SEND, state IDLE, next requester granted.
